ro_puf_ctrl: RTL and testbench
==============================

// Module: ro_puf_ctrl
// PURPOSE
//  Measurement sequencer for the RO-PUF array of RO_Slice_En cells. Per challenge it
//  enables two ROs, sets their shared SEL/Bx config, counts rising edges of each
//  LATCH_OUT for a fixed window, compares the counts and returns one response bit.
//  Sits between the challenge source (host/UART) and the RO array.
// PARAMETERS
//  N_RO    16    number of RO slices driven (ro_en width)
//  IDX_W   4     RO index width, N_RO <= 2**IDX_W
//  CNT_W   16    edge-counter width
//  WINDOW  1024  measurement window, clk cycles (>=1)
//  SETTLE  4     cycles ROs run before counting starts (>=1)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active-high
//  start      in   1      request measurement; sampled only in IDLE
//  idx_a      in   IDX_W  first RO index, latched with start
//  idx_b      in   IDX_W  second RO index, latched with start
//  cfg        in   2      {Bx,SEL} for both ROs, latched with start
//  ro_in_a    in   1      LATCH_OUT of RO idx_a (async to clk)
//  ro_in_b    in   1      LATCH_OUT of RO idx_b (async to clk)
//  ro_en      out  N_RO   per-slice EN; only bits idx_a, idx_b ever set
//  ro_sel     out  1      SEL to all slices
//  ro_bx      out  1      Bx to all slices
//  busy       out  1      high in every state except IDLE
//  resp_valid out  1      one-cycle pulse, response/cnt_*/tie valid
//  response   out  1      1 when cnt_a > cnt_b
//  tie        out  1      1 when cnt_a == cnt_b
//  err        out  1      one-cycle pulse: illegal challenge rejected
//  cnt_a      out  CNT_W  final edge count of RO a (held until next start)
//  cnt_b      out  CNT_W  final edge count of RO b
// BEHAVIOUR
//  Reset: state IDLE; ro_en=0, ro_sel=0, ro_bx=0, busy=0, resp_valid=0, err=0,
//   response=0, tie=0, cnt_a=cnt_b=0, sync/edge flops=0, timer=0.
//  FSM: IDLE -> SETTLE -> MEASURE -> DRAIN -> DONE -> IDLE.
//  IDLE: on start=1: if idx_a==idx_b or either idx >= N_RO -> err=1 next cycle,
//   stay IDLE, no RO enabled. Else latch idx/cfg, clear counters, go SETTLE.
//  SETTLE: ro_en[idx_a]=ro_en[idx_b]=1, ro_sel/ro_bx=cfg; SETTLE cycles, no counting.
//  MEASURE: ROs still enabled; WINDOW cycles; counters increment on synced rising edge.
//  DRAIN: ro_en=0; 2 cycles; counting stopped (edges ignored).
//  DONE: 1 cycle; resp_valid=1, response/tie/cnt_* registered from counters.
//  Latency: start in cycle 0 -> resp_valid in cycle 1+SETTLE+WINDOW+2.
//  ro_in path: 2-flop synchronizer + 1 delay flop; edge = s2 & ~s3. Inputs must
//   toggle slower than clk/2 (prescale in RO domain otherwise); faster is undefined.
//  Counters saturate at 2**CNT_W-1, never wrap; saturated compare still valid.
//  start while busy: ignored, not queued. start in DONE cycle: ignored.
//  ro_sel/ro_bx keep last cfg in IDLE; ro_en is 0 outside SETTLE/MEASURE.
//  rst mid-operation: next edge all outputs at reset values, no resp_valid.
// TESTING
//  T1 WINDOW=16,SETTLE=4: start idx_a=2 idx_b=5, ro_in_a period 4clk, ro_in_b 6clk
//     -> ro_en=0x0024 cycles 1..20, resp_valid cycle 23, cnt_a=4, cnt_b=2-3, response=1.
//  T2 same, swapped periods -> response=0, tie=0; ro_en=0 from cycle 21.
//  T3 identical 4clk toggles phase-aligned -> cnt_a==cnt_b=4, tie=1, response=0.
//  T4 start idx_a=idx_b=7 -> err pulse cycle 1, busy=0, ro_en stays 0, no resp_valid;
//     idx_a=16 with N_RO=16 -> same.
//  T5 CNT_W=3, ro_in_a 4clk period over WINDOW=64 -> cnt_a=7 (saturated), response=1.
//  T6 start, then start pulses during MEASURE, then rst at cycle 10 -> extra starts
//     ignored; after rst ro_en=0, busy=0, no resp_valid; new start completes normally.

Source files
------------

// File: rtl/ro_puf_ctrl.sv
// RO-PUF measurement sequencer: enables an RO pair, counts synchronized rising
// edges of both LATCH_OUTs over a fixed window and returns the comparison bit.
module ro_puf_ctrl #(
   parameter int unsigned N_RO   = 16,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned WINDOW = 1024,
   parameter int unsigned SETTLE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IDX_W-1:0]  idx_a,
   input  logic [IDX_W-1:0]  idx_b,
   input  logic [1:0]        cfg,
   input  logic              ro_in_a,
   input  logic              ro_in_b,
   output logic [N_RO-1:0]   ro_en,
   output logic              ro_sel,
   output logic              ro_bx,
   output logic              busy,
   output logic              resp_valid,
   output logic              response,
   output logic              tie,
   output logic              err,
   output logic [CNT_W-1:0]  cnt_a,
   output logic [CNT_W-1:0]  cnt_b
);

   localparam int unsigned TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_MEASURE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state;
   logic [TMR_W-1:0]  timer;
   logic [CNT_W-1:0]  ctr_a;
   logic [CNT_W-1:0]  ctr_b;
   logic [2:0]        sync_a;
   logic [2:0]        sync_b;
   logic              rise_a_c;
   logic              rise_b_c;
   logic              illegal_c;
   logic [N_RO-1:0]   en_mask_c;

   // sync_x[1] is the second synchronizer stage, sync_x[2] the edge-detect delay
   assign rise_a_c  = sync_a[1] & ~sync_a[2];
   assign rise_b_c  = sync_b[1] & ~sync_b[2];
   assign illegal_c = (idx_a == idx_b) || (32'(idx_a) >= N_RO) || (32'(idx_b) >= N_RO);

   always_comb begin
      en_mask_c = '0;
      for (int unsigned i = 0; i < N_RO; i++) begin
         en_mask_c[i] = (IDX_W'(i) == idx_a) || (IDX_W'(i) == idx_b);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         timer      <= '0;
         ctr_a      <= '0;
         ctr_b      <= '0;
         sync_a     <= '0;
         sync_b     <= '0;
         ro_en      <= '0;
         ro_sel     <= 1'b0;
         ro_bx      <= 1'b0;
         busy       <= 1'b0;
         resp_valid <= 1'b0;
         response   <= 1'b0;
         tie        <= 1'b0;
         err        <= 1'b0;
         cnt_a      <= '0;
         cnt_b      <= '0;
      end else begin
         sync_a     <= {sync_a[1:0], ro_in_a};
         sync_b     <= {sync_b[1:0], ro_in_b};
         err        <= 1'b0;
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (illegal_c) begin
                     err <= 1'b1;
                  end else begin
                     state  <= S_SETTLE;
                     busy   <= 1'b1;
                     timer  <= '0;
                     ctr_a  <= '0;
                     ctr_b  <= '0;
                     ro_en  <= en_mask_c;
                     ro_sel <= cfg[0];
                     ro_bx  <= cfg[1];
                  end
               end
            end
            S_SETTLE: begin
               if (timer == TMR_W'(SETTLE - 1)) begin
                  timer <= '0;
                  state <= S_MEASURE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_MEASURE: begin
               // Counters saturate instead of wrapping so the compare stays meaningful
               if (rise_a_c && (ctr_a != '1)) ctr_a <= ctr_a + CNT_W'(1);
               if (rise_b_c && (ctr_b != '1)) ctr_b <= ctr_b + CNT_W'(1);
               if (timer == TMR_W'(WINDOW - 1)) begin
                  timer <= '0;
                  ro_en <= '0;
                  state <= S_DRAIN;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_DRAIN: begin
               if (timer == TMR_W'(1)) begin
                  timer      <= '0;
                  state      <= S_DONE;
                  resp_valid <= 1'b1;
                  response   <= (ctr_a > ctr_b);
                  tie        <= (ctr_a == ctr_b);
                  cnt_a      <= ctr_a;
                  cnt_b      <= ctr_b;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               ro_en <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Scoreboard bench for ro_puf_ctrl: a short-window instance and a 3-bit-counter
// instance share RO inputs; expected responses are queued and popped on resp_valid.
module tb_ro_puf_ctrl;

   typedef struct {
      int unsigned cyc;
      bit          resp;
      bit          tie;
      int unsigned ca;
      int unsigned cb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   logic [4:0]  idx_a = '0;
   logic [4:0]  idx_b = '0;
   logic [1:0]  cfg = '0;
   logic        ro_a = 1'b0;
   logic        ro_b = 1'b0;

   logic [15:0] en0, en1;
   logic        sel0, bx0, busy0, rv0, resp0, tie0, err0;
   logic        sel1, bx1, busy1, rv1, resp1, tie1, err1;
   logic [15:0] ca0, cb0;
   logic [2:0]  ca1, cb1;

   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        m0, m1;

   ro_puf_ctrl #(.N_RO(16), .IDX_W(5), .CNT_W(16), .WINDOW(16), .SETTLE(4)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .idx_a(idx_a), .idx_b(idx_b), .cfg(cfg),
      .ro_in_a(ro_a), .ro_in_b(ro_b), .ro_en(en0), .ro_sel(sel0), .ro_bx(bx0),
      .busy(busy0), .resp_valid(rv0), .response(resp0), .tie(tie0), .err(err0),
      .cnt_a(ca0), .cnt_b(cb0));

   ro_puf_ctrl #(.N_RO(16), .IDX_W(5), .CNT_W(3), .WINDOW(64), .SETTLE(4)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .idx_a(idx_a), .idx_b(idx_b), .cfg(cfg),
      .ro_in_a(ro_a), .ro_in_b(ro_b), .ro_en(en1), .ro_sel(sel1), .ro_bx(bx1),
      .busy(busy1), .resp_valid(rv1), .response(resp1), .tie(tie1), .err(err1),
      .cnt_a(ca1), .cnt_b(cb1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop and compare whenever either instance presents a response
   always @(negedge clk) begin
      if (rv0) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL d0 unexpected resp_valid: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            m0 = q0.pop_front();
            chk("d0 resp cycle", cyc, m0.cyc);
            chk("d0 response", 32'(resp0), 32'(m0.resp));
            chk("d0 tie", 32'(tie0), 32'(m0.tie));
            chk("d0 cnt_a", 32'(ca0), m0.ca);
            chk("d0 cnt_b", 32'(cb0), m0.cb);
         end
      end
      if (rv1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL d1 unexpected resp_valid: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            m1 = q1.pop_front();
            chk("d1 resp cycle", cyc, m1.cyc);
            chk("d1 response", 32'(resp1), 32'(m1.resp));
            chk("d1 tie", 32'(tie1), 32'(m1.tie));
            chk("d1 cnt_a", 32'(ca1), m1.ca);
            chk("d1 cnt_b", 32'(cb1), m1.cb);
         end
      end
   end

   // One measurement: toggle ro_a every ha cycles and ro_b every hb (0 = quiet)
   task automatic run(input bit which, input logic [4:0] ia, input logic [4:0] ib,
                      input logic [1:0] c, input int ha, input int hb, input int span,
                      input bit extra, input bit e_resp, input bit e_tie,
                      input int unsigned e_ca, input int unsigned e_cb);
      exp_t        e;
      logic [15:0] mask;
      logic [15:0] en;
      int          ncyc;
      ncyc = span + 6;
      @(negedge clk);
      mask  = (16'(1) << ia) | (16'(1) << ib);
      e.cyc = cyc + 32'(span) + 3;
      e.resp = e_resp; e.tie = e_tie; e.ca = e_ca; e.cb = e_cb;
      if (which) q1.push_back(e); else q0.push_back(e);
      idx_a = ia; idx_b = ib; cfg = c;
      if (which) start1 = 1'b1; else start0 = 1'b1;
      for (int cy = 1; cy <= ncyc; cy++) begin
         @(negedge clk);
         start0 = 1'b0; start1 = 1'b0;
         if (extra && (cy == 8 || cy == span + 3)) begin
            if (which) start1 = 1'b1; else start0 = 1'b1;
         end
         if (ha != 0 && cy % ha == 0) ro_a = ~ro_a;
         if (hb != 0 && cy % hb == 0) ro_b = ~ro_b;
         en = which ? en1 : en0;
         chk("ro_en", 32'(en), (cy <= span) ? 32'(mask) : 0);
         if (cy == 1)
            chk("busy after start", 32'(which ? busy1 : busy0), 1);
         if (cy == 2 || cy == ncyc) begin
            chk("ro_sel", 32'(which ? sel1 : sel0), 32'(c[0]));
            chk("ro_bx", 32'(which ? bx1 : bx0), 32'(c[1]));
         end
         if (cy == span + 4)
            chk("busy after done", 32'(which ? busy1 : busy0), 0);
      end
      start0 = 1'b0; start1 = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic err_test(input logic [4:0] ia, input logic [4:0] ib);
      @(negedge clk);
      idx_a = ia; idx_b = ib; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("err pulse", 32'(err0), 1);
      chk("err busy", 32'(busy0), 0);
      chk("err ro_en", 32'(en0), 0);
      @(negedge clk);
      chk("err cleared", 32'(err0), 0);
      chk("err ro_en later", 32'(en0), 0);
      repeat (30) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst ro_en", 32'(en0), 0);
      chk("rst busy", 32'(busy0), 0);
      chk("rst resp_valid", 32'(rv0), 0);
      chk("rst err", 32'(err0), 0);
      chk("rst cnt_a", 32'(ca0), 0);
      chk("rst sel/bx", 32'({sel0, bx0}), 0);
      chk("rst d1 busy", 32'(busy1), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // T1/T2/T3: a period 4 -> 4 edges, period 6 -> 3 edges
      run(1'b0, 5'd2, 5'd5, 2'b10, 2, 3, 20, 1'b0, 1'b1, 1'b0, 4, 3);
      run(1'b0, 5'd2, 5'd5, 2'b01, 3, 2, 20, 1'b0, 1'b0, 1'b0, 3, 4);
      run(1'b0, 5'd0, 5'd15, 2'b11, 2, 2, 20, 1'b0, 1'b0, 1'b1, 4, 4);
      // Extra starts during MEASURE and in DONE are ignored
      run(1'b0, 5'd3, 5'd9, 2'b00, 2, 3, 20, 1'b1, 1'b1, 1'b0, 4, 3);

      // T4: illegal challenges
      err_test(5'd7, 5'd7);
      err_test(5'd16, 5'd3);
      err_test(5'd4, 5'd20);

      // T5: 3-bit counters saturate over the 64-cycle window
      run(1'b1, 5'd1, 5'd3, 2'b01, 2, 0, 68, 1'b0, 1'b1, 1'b0, 7, 0);
      run(1'b1, 5'd1, 5'd3, 2'b10, 2, 2, 68, 1'b0, 1'b0, 1'b1, 7, 7);

      // T6: reset mid-measurement aborts without a response
      @(negedge clk);
      idx_a = 5'd2; idx_b = 5'd5; cfg = 2'b11; start0 = 1'b1;
      for (int cy = 1; cy <= 12; cy++) begin
         @(negedge clk);
         start0 = (cy == 6 || cy == 7);
         rst    = (cy == 10);
         if (cy % 2 == 0) ro_a = ~ro_a;
         if (cy == 3) chk("pre-rst busy", 32'(busy0), 1);
         if (cy == 11) begin
            chk("post-rst ro_en", 32'(en0), 0);
            chk("post-rst busy", 32'(busy0), 0);
            chk("post-rst resp_valid", 32'(rv0), 0);
            chk("post-rst cnt_a", 32'(ca0), 0);
            chk("post-rst sel", 32'(sel0), 0);
         end
      end
      start0 = 1'b0; rst = 1'b0; ro_a = 1'b0;
      repeat (30) @(negedge clk);
      run(1'b0, 5'd2, 5'd5, 2'b10, 2, 3, 20, 1'b0, 1'b1, 1'b0, 4, 3);

      chk("d0 queue drained", q0.size(), 0);
      chk("d1 queue drained", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
